// File: rtl/wb_pkg.sv
// Shared widths and the load-writeback entry record for the writeback sequencer.
package wb_pkg;

   localparam int WB_DATA_W  = 32;
   localparam int WB_RADDR_W = 6;
   localparam int WB_DEPTH   = 4;

   // One queued load writeback: destination register and data.
   typedef struct packed {
      logic [WB_RADDR_W-1:0] dr;
      logic [WB_DATA_W-1:0]  wd;
   } ld_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-writeback FIFO. The valid window is defined only by the read pointer
// and the count, so the storage array itself is never reset.
module wb_fifo import wb_pkg::*; #(
   parameter  int DEPTH   = WB_DEPTH,
   parameter  int DATA_W  = WB_DATA_W,
   parameter  int RADDR_W = WB_RADDR_W,
   localparam int PW      = $clog2(DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [RADDR_W-1:0]       push_dr_i,
   input  logic [DATA_W-1:0]        push_wd_i,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [CW-1:0]            count_o,
   output logic [RADDR_W-1:0]       head_dr_o,
   output logic [DATA_W-1:0]        head_wd_o,
   output logic [DEPTH-1:0]         ent_vld_o,
   output logic [DEPTH*RADDR_W-1:0] ent_dr_o
);

   logic [RADDR_W-1:0] dr_mem [DEPTH];
   logic [DATA_W-1:0]  wd_mem [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;

   assign full_o    = (cnt_q == CW'(DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign count_o   = cnt_q;
   assign push_ok   = push_i && !full_o;
   assign pop_ok    = pop_i && !empty_o;
   assign head_dr_o = dr_mem[rd_ptr_q];
   assign head_wd_o = wd_mem[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      cnt_d    = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Entry storage, written only on an accepted push.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         dr_mem[wr_ptr_q] <= push_dr_i;
         wd_mem[wr_ptr_q] <= push_wd_i;
      end
   end

   // Per-entry valid flag: entry i is live when its distance from the head is below the count.
   always_comb begin
      logic [PW-1:0] offs;
      offs      = '0;
      ent_vld_o = '0;
      ent_dr_o  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs                          = PW'(i) - rd_ptr_q;
         ent_vld_o[i]                  = ({1'b0, offs} < cnt_q);
         ent_dr_o[i*RADDR_W +: RADDR_W] = dr_mem[i];
      end
   end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: merges an unstallable ALU writeback stream with queued
// load writebacks onto two register-bank write ports. A queued load never
// issues in the same cycle as an ALU write to the same register (ALU wins).
module wb_sequencer import wb_pkg::*; #(
   parameter  int DEPTH   = WB_DEPTH,
   parameter  int DATA_W  = WB_DATA_W,
   parameter  int RADDR_W = WB_RADDR_W,
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ALU_V,
   input  logic [RADDR_W-1:0] ALU_DR,
   input  logic [DATA_W-1:0]  ALU_WD,
   input  logic               LD_V,
   output logic               LD_RDY,
   input  logic [RADDR_W-1:0] LD_DR,
   input  logic [DATA_W-1:0]  LD_WD,
   input  logic [RADDR_W-1:0] Q_REG,
   output logic               Q_PEND,
   output logic               WE_A,
   output logic [RADDR_W-1:0] DR,
   output logic [DATA_W-1:0]  WD,
   output logic               WE_M,
   output logic [RADDR_W-1:0] W_INST,
   output logic [DATA_W-1:0]  MEM_WD,
   output logic [CW-1:0]      FIFO_CNT
);

   logic                     fifo_full, fifo_empty;
   logic [RADDR_W-1:0]       head_dr;
   logic [DATA_W-1:0]        head_wd;
   logic [DEPTH-1:0]         ent_vld;
   logic [DEPTH*RADDR_W-1:0] ent_dr;
   logic                     issue;

   logic               we_a_q, we_a_d;
   logic [RADDR_W-1:0] dr_q, dr_d;
   logic [DATA_W-1:0]  wd_q, wd_d;
   logic               we_m_q, we_m_d;
   logic [RADDR_W-1:0] w_inst_q, w_inst_d;
   logic [DATA_W-1:0]  mem_wd_q, mem_wd_d;

   assign LD_RDY = !fifo_full && !RST;
   // The head is held back whenever the ALU writes the same register this cycle.
   assign issue  = !fifo_empty && !(ALU_V && (ALU_DR == head_dr));

   wb_fifo #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .RADDR_W (RADDR_W)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .push_i    (LD_V && LD_RDY),
      .pop_i     (issue),
      .push_dr_i (LD_DR),
      .push_wd_i (LD_WD),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .count_o   (FIFO_CNT),
      .head_dr_o (head_dr),
      .head_wd_o (head_wd),
      .ent_vld_o (ent_vld),
      .ent_dr_o  (ent_dr)
   );

   // Next values of both write ports; address/data hold when the port is idle.
   always_comb begin
      we_a_d   = ALU_V;
      dr_d     = ALU_V ? ALU_DR : dr_q;
      wd_d     = ALU_V ? ALU_WD : wd_q;
      we_m_d   = issue;
      w_inst_d = issue ? head_dr : w_inst_q;
      mem_wd_d = issue ? head_wd : mem_wd_q;
   end

   // Write-port output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         we_a_q   <= 1'b0;
         dr_q     <= '0;
         wd_q     <= '0;
         we_m_q   <= 1'b0;
         w_inst_q <= '0;
         mem_wd_q <= '0;
      end else begin
         we_a_q   <= we_a_d;
         dr_q     <= dr_d;
         wd_q     <= wd_d;
         we_m_q   <= we_m_d;
         w_inst_q <= w_inst_d;
         mem_wd_q <= mem_wd_d;
      end
   end

   // Pending-write query across queued entries and both write ports.
   always_comb begin
      Q_PEND = (we_a_q && (dr_q == Q_REG)) || (we_m_q && (w_inst_q == Q_REG));
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && (ent_dr[i*RADDR_W +: RADDR_W] == Q_REG)) Q_PEND = 1'b1;
      end
   end

   assign WE_A   = we_a_q;
   assign DR     = dr_q;
   assign WD     = wd_q;
   assign WE_M   = we_m_q;
   assign W_INST = w_inst_q;
   assign MEM_WD = mem_wd_q;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: load-writeback FIFO depth, power of two, 2..16.
REQ-002 Parameter DATA_W, default 32: register data width.
REQ-003 Parameter RADDR_W, default 6: register index width (64-entry register bank).
REQ-004 CLK  in  1  single clock; all state updates on posedge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 ALU_V  in  1  ALU writeback valid; no backpressure.
REQ-007 ALU_DR  in  RADDR_W  ALU destination register.
REQ-008 ALU_WD  in  DATA_W  ALU result.
REQ-009 LD_V  in  1  load writeback valid.
REQ-010 LD_RDY  out  1  FIFO can accept a load this cycle.
REQ-011 LD_DR  in  RADDR_W  load destination register.
REQ-012 LD_WD  in  DATA_W  load data.
REQ-013 Q_REG  in  RADDR_W  register index for pending-write query.
REQ-014 Q_PEND  out  1  a write to Q_REG is queued or being presented.
REQ-015 WE_A / DR / WD  out  1 / RADDR_W / DATA_W  ALU write port to register bank.
REQ-016 WE_M / W_INST / MEM_WD  out  1 / RADDR_W / DATA_W  memory write port to register bank.
REQ-017 FIFO_CNT  out  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 ALU path: ALU_V=1 in cycle n SHALL give WE_A=1, DR=ALU_DR, WD=ALU_WD registered in cycle n+1; ALU_V=0 gives WE_A=0 in n+1, DR/WD holding.
REQ-019 LD_RDY SHALL equal (FIFO_CNT < DEPTH) and RST low; a load is accepted iff LD_V && LD_RDY on a clock edge.
REQ-020 LD_V while LD_RDY=0 SHALL be ignored; data is not captured, and the source holds it.
REQ-021 Issue rule, cycle n: FIFO head issues iff FIFO non-empty and NOT (ALU_V && ALU_DR == head DR); the head stays otherwise.
REQ-022 Issued head SHALL appear as WE_M=1, W_INST, MEM_WD in cycle n+1; WE_M=0 when nothing issues.
REQ-023 A load accepted in cycle n SHALL be eligible to issue no earlier than cycle n+1 (minimum latency 2 cycles to WE_M); there is no bypass.
REQ-024 Loads SHALL issue in acceptance order; at most one issue per cycle.
REQ-025 Simultaneous accept and issue SHALL leave FIFO_CNT unchanged; pointers wrap modulo DEPTH.
REQ-026 WE_A and WE_M SHALL never both be 1 with DR == W_INST (guaranteed by REQ-021).
REQ-027 Q_PEND (combinational) = 1 iff any valid FIFO entry has DR == Q_REG, or (WE_A && DR == Q_REG), or (WE_M && W_INST == Q_REG).
REQ-028 A continuous ALU stream to the head's register SHALL stall the FIFO indefinitely; this is the intended priority (ALU wins).

Reset
REQ-029 RST high SHALL asynchronously clear FIFO_CNT, pointers, WE_A, WE_M, DR, WD, W_INST, MEM_WD to 0; LD_RDY=0 and Q_PEND=0 while RST is high.
REQ-030 Reset mid-operation SHALL discard all queued loads; no write port asserts in the first cycle after release.
REQ-031 FIFO data storage needs no reset; valid state is carried only by the pointers and the count.

Structure
REQ-032 Package wb_pkg SHALL hold DATA_W, RADDR_W, default DEPTH, and the load-entry record (dr, wd).
REQ-033 The FIFO SHALL be a sub-module wb_fifo (push/pop/full/empty/count, head outputs, plus per-entry DR vector for Q_PEND).
REQ-034 The top level contains the issue/conflict logic, the output registers, and the Q_PEND compare.

Verification
REQ-035 Reset, then ALU_V=1, ALU_DR=5, ALU_WD=0xDEADBEEF in cycle 1 -> WE_A=1, DR=5, WD=0xDEADBEEF in cycle 2; WE_M=0.
REQ-036 Loads to r1..r4 (data 0x11..0x44) on 4 consecutive cycles, no ALU -> writes appear on WE_M in order r1..r4 starting 2 cycles after the first; FIFO_CNT peaks at 1.
REQ-037 Hold the issue blocked (ALU_V=1 with ALU_DR=r9 while the head is r9), push 5 loads -> LD_RDY=0 after 4 loads, the 5th is ignored, FIFO_CNT=4; release -> 4 writes in order.
REQ-038 Head r7 queued, ALU_V=1 ALU_DR=7 for 3 cycles -> WE_M=0 for those cycles, three WE_A writes to r7, then the load to r7 issues in the following cycle; Q_PEND(Q_REG=7)=1 throughout.
REQ-039 FIFO holds 3 entries, assert RST for 1 cycle mid-stream -> all outputs 0 asynchronously, FIFO_CNT=0, no stale WE_M after release.
REQ-040 Push and issue in the same cycle at FIFO_CNT=2 -> FIFO_CNT stays 2; run 20 such cycles to exercise pointer wrap with ordering intact.
